pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central hazard/stall scheduler for the 5-stage RV64 pipeline. Drives the 2-bit stall code of PC, IF/ID, ID/EX, EX/ME, ME/WB.
//  Resolves simultaneous hazards by fixed priority. Holds a branch redirect that arrives during an I-fetch wait.
//  Watchdogs bus waits.
// PARAMETERS
//  TIMEOUT_CYC  1024  consecutive imem/dmem busy cycles before bus_timeout sets (>=2)
//  CNT_W        32    width of wait and perf counters
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous active-high reset
//  imem_busy       in   1   IF fetch not yet returned
//  dmem_busy       in   1   ME load/store not yet acked
//  ex_busy         in   1   EX multi-cycle op (mul/div) in progress
//  load_use        in   1   ID needs the result of the load now in EX
//  br_taken        in   1   EX resolved a taken branch or jump
//  br_target       in   64  redirect target, valid with br_taken
//  pc_stall        out  2   stall code for the PC register
//  if_id_stall     out  2   stall code for IF/ID
//  id_ex_stall     out  2   stall code for ID/EX
//  ex_me_stall     out  2   stall code for EX/ME
//  me_wb_stall     out  2   stall code for ME/WB
//  redirect_vld    out  1   PC loads redirect_pc this cycle
//  redirect_pc     out  64  redirect target
//  bus_timeout     out  1   sticky watchdog flag
//  stall_cnt       out  CNT_W  perf: cycles with pc_stall==KEEP (STALL_PERF_EN only)
// BEHAVIOUR
//  Codes: STALL_NEXT=2'b00 load, STALL_KEEP=2'b01 hold, STALL_ZERO=2'b10 bubble. Stall outputs are combinational from inputs+state.
//  While rst=1: all stall outputs ZERO; redirect_vld=0, redirect_pc=0, bus_timeout=0, stall_cnt=0, state=RUN, wait_cnt=0.
//  Priority, first match wins; outputs listed as pc/if_id/id_ex/ex_me/me_wb:
//   1 dmem_busy : KEEP/KEEP/KEEP/KEEP/ZERO
//   2 ex_busy   : KEEP/KEEP/KEEP/ZERO/NEXT
//   3 br_taken  : NEXT/ZERO/ZERO/NEXT/NEXT. Also redirect_vld=1, redirect_pc=br_target. load_use is ignored (wrong path).
//   4 load_use  : KEEP/KEEP/ZERO/NEXT/NEXT
//   5 imem_busy : KEEP/ZERO/NEXT/NEXT/NEXT
//   6 none      : all NEXT
//  br_taken under 1/2 is not consumed. EX holds the branch, so it re-presents next cycle.
//  FSM RUN/REDIR_PEND:
//   RUN -> REDIR_PEND when case 3 fires with imem_busy=1. The in-flight fetch is wrong-path.
//    Latch br_target into pend_pc. redirect_vld is NOT asserted in that cycle. PC gets KEEP instead of NEXT.
//   In REDIR_PEND: pc=KEEP and if_id=ZERO while imem_busy=1 (cases 1/2 still override).
//    On the first cycle imem_busy=0: redirect_vld=1, redirect_pc=pend_pc, pc=NEXT, if_id=ZERO, then -> RUN.
//   In REDIR_PEND, a new br_taken is impossible: EX holds only bubbles. If it occurs, it overwrites pend_pc.
//  Watchdog: wait_cnt += 1 each cycle (imem_busy|dmem_busy), else clears to 0; saturates at TIMEOUT_CYC.
//   bus_timeout sets when wait_cnt==TIMEOUT_CYC-1 and busy is still high. Cleared only by rst.
//  Reset mid-wait/mid-REDIR_PEND: next cycle is RUN with pend_pc discarded.
// CONFIGURATION
//  STALL_PERF_EN defined: stall_cnt increments each non-reset cycle with pc_stall==KEEP; wraps at 2^CNT_W.
//  STALL_PERF_EN undefined: no counter flop; stall_cnt tied to 0.
// STRUCTURE
//  defines.v: STALL_NEXT/KEEP/ZERO codes, REG_BUS, FSM state encodings.
//  Sub-module bus_watchdog (counter + sticky flag), instantiated once. Everything else is inline.
// TESTING
//  1 Idle, no hazards -> all five codes 2'b00 every cycle, redirect_vld=0.
//  2 dmem_busy=1 for 3 cycles with load_use=1 -> 3 cycles KEEP/KEEP/KEEP/KEEP/ZERO; load_use result appears only after release.
//  3 br_taken=1, target 0x8000_0100, imem_busy=0 -> same cycle redirect_vld=1, pc NEXT, if_id/id_ex ZERO.
//  4 br_taken=1, target 0x8000_0200, imem_busy=1 for 4 more cycles -> REDIR_PEND, pc KEEP.
//    redirect_vld=1 with 0x8000_0200 exactly in the first imem_busy=0 cycle.
//  5 TIMEOUT_CYC=8, dmem_busy held 8 cycles -> bus_timeout rises at the 8th busy cycle and stays high after busy drops.
//  6 rst pulsed during REDIR_PEND -> all codes ZERO during reset; afterwards RUN, no stale redirect.
//    With STALL_PERF_EN: stall_cnt back to 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: stall codes, FSM states and
// the per-stage stall vector.
package pipe_stall_ctrl_pkg;

  localparam int unsigned XLEN = 64;

  // Per-register stall code: load next value, hold current, or insert a bubble.
  typedef enum logic [1:0] {
    StallNext = 2'b00,
    StallKeep = 2'b01,
    StallZero = 2'b10
  } stall_e;

  typedef enum logic [0:0] {
    StRun       = 1'b0,
    StRedirPend = 1'b1
  } state_e;

  typedef struct packed {
    stall_e pc;
    stall_e if_id;
    stall_e id_ex;
    stall_e ex_me;
    stall_e me_wb;
  } stall_vec_t;

  function automatic stall_vec_t stall_vec(stall_e pc, stall_e if_id, stall_e id_ex,
                                           stall_e ex_me, stall_e me_wb);
    stall_vec_t v;
    v.pc    = pc;
    v.if_id = if_id;
    v.id_ex = id_ex;
    v.ex_me = ex_me;
    v.me_wb = me_wb;
    return v;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/redirect outputs between the pipeline and the
// stall controller. The pipeline side is the master, the controller the slave.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_stall_ctrl_pkg::*;

  logic             imem_busy;
  logic             dmem_busy;
  logic             ex_busy;
  logic             load_use;
  logic             br_taken;
  logic [XLEN-1:0]  br_target;
  logic [1:0]       pc_stall;
  logic [1:0]       if_id_stall;
  logic [1:0]       id_ex_stall;
  logic [1:0]       ex_me_stall;
  logic [1:0]       me_wb_stall;
  logic             redirect_vld;
  logic [XLEN-1:0]  redirect_pc;
  logic             bus_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output imem_busy, dmem_busy, ex_busy, load_use, br_taken, br_target,
    input  pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall,
    input  redirect_vld, redirect_pc, bus_timeout, stall_cnt
  );

  modport slave (
    input  imem_busy, dmem_busy, ex_busy, load_use, br_taken, br_target,
    output pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall,
    output redirect_vld, redirect_pc, bus_timeout, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_bus_watchdog.sv
// Counts consecutive bus-busy cycles and raises a sticky timeout flag once
// TIMEOUT_CYC busy cycles have elapsed. Only reset clears the flag.
module pipe_stall_ctrl_bus_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic bus_timeout
);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // Saturating busy-cycle counter plus sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (!busy) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if (busy && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus_timeout = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall scheduler for the 5-stage pipeline. Resolves hazards by
// fixed priority and parks a branch redirect that lands during an I-fetch wait.
// Optional feature macro: STALL_PERF_EN adds a PC-hold cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  stall_vec_t      stall;
  logic            hold;

  // Back-end stalls (dmem/ex) freeze everything, including redirect handling.
  assign hold = bus.dmem_busy | bus.ex_busy;

  // State register and parked redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next state: park a redirect while the wrong-path fetch drains.
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      StRun: begin
        if (!hold && bus.br_taken && bus.imem_busy) begin
          state_d   = StRedirPend;
          pend_pc_d = bus.br_target;
        end
      end
      StRedirPend: begin
        if (!hold) begin
          if (!bus.imem_busy) begin
            state_d = StRun;
          end else if (bus.br_taken) begin
            pend_pc_d = bus.br_target;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs: fixed-priority stall codes and redirect.
  always_comb begin
    stall            = stall_vec(StallNext, StallNext, StallNext, StallNext, StallNext);
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = '0;
    if (rst) begin
      stall = stall_vec(StallZero, StallZero, StallZero, StallZero, StallZero);
    end else if (bus.dmem_busy) begin
      stall = stall_vec(StallKeep, StallKeep, StallKeep, StallKeep, StallZero);
    end else if (bus.ex_busy) begin
      stall = stall_vec(StallKeep, StallKeep, StallKeep, StallZero, StallNext);
    end else if (state_q == StRedirPend) begin
      if (bus.imem_busy) begin
        stall = stall_vec(StallKeep, StallZero, StallNext, StallNext, StallNext);
      end else begin
        stall            = stall_vec(StallNext, StallZero, StallNext, StallNext, StallNext);
        bus.redirect_vld = 1'b1;
        bus.redirect_pc  = pend_pc_q;
      end
    end else if (bus.br_taken) begin
      if (bus.imem_busy) begin
        // Fetch in flight is wrong-path: hold PC until it returns.
        stall = stall_vec(StallKeep, StallZero, StallZero, StallNext, StallNext);
      end else begin
        stall            = stall_vec(StallNext, StallZero, StallZero, StallNext, StallNext);
        bus.redirect_vld = 1'b1;
        bus.redirect_pc  = bus.br_target;
      end
    end else if (bus.load_use) begin
      stall = stall_vec(StallKeep, StallKeep, StallZero, StallNext, StallNext);
    end else if (bus.imem_busy) begin
      stall = stall_vec(StallKeep, StallZero, StallNext, StallNext, StallNext);
    end
  end

  assign bus.pc_stall    = stall.pc;
  assign bus.if_id_stall = stall.if_id;
  assign bus.id_ex_stall = stall.id_ex;
  assign bus.ex_me_stall = stall.ex_me;
  assign bus.me_wb_stall = stall.me_wb;

  pipe_stall_ctrl_bus_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_bus_watchdog (
    .clk        (clk),
    .rst        (rst),
    .busy       (bus.imem_busy | bus.dmem_busy),
    .bus_timeout(bus.bus_timeout)
  );

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall.pc == StallKeep) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
